// File: rtl/bcd_adder_serial.sv
// ---------------------------------------------------------------------------
// bcd_adder_serial
//
// Digit-serial BCD adder with a four-phase handshake on both sides. Producer
// handshake: soc out, eoc in (A and B). Consumer handshake: davC_ out
// (active-low), rfdC in. Two N-digit packed BCD operands are captured when
// both producers report end-of-conversion. They are then added one digit per
// clock, least significant digit first, into the registered result z. The
// sum is offered to consumer C.
//
// Parameters
//   N        number of BCD digits per operand (1..16)
//
// Ports
//   clock    system clock, rising edge
//   reset_   asynchronous active-low reset
//   socA/B   start-of-conversion to producers A and B (one shared register)
//   eocA/B   end-of-conversion from producers A and B
//   a, b     operands, digit i in bits 4i+3..4i, digit 0 least significant
//   davC_    data-valid to consumer C, active-low
//   rfdC     ready-for-data from consumer C
//   z        BCD sum, N+1 digits, digit N is the final carry
//   err      (BCD_ADDER_SERIAL_CHECK_EN only) a captured digit exceeded 9
//
// Optional feature macro: BCD_ADDER_SERIAL_CHECK_EN
//   When defined, an err output is added. A non-BCD digit in either captured
//   operand sets err on entry to DAV and forces every digit of z to 9.
// ---------------------------------------------------------------------------
module bcd_adder_serial #(
  parameter int unsigned N = 4
) (
  input  logic             clock,
  input  logic             reset_,
  output logic             socA,
  output logic             socB,
  input  logic             eocA,
  input  logic             eocB,
  input  logic [4*N-1:0]   a,
  input  logic [4*N-1:0]   b,
  output logic             davC_,
  input  logic             rfdC,
  output logic [4*N+3:0]   z
`ifdef BCD_ADDER_SERIAL_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_START,
    S_WAIT,
    S_ADD,
    S_DAV,
    S_END
  } state_e;

  state_e            state_q, state_d;
  logic              soc_q, soc_d;
  logic              dav_n_q, dav_n_d;
  logic [4*N+3:0]    z_q, z_d;
  logic [4*N-1:0]    a_q, a_d;
  logic [4*N-1:0]    b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;

`ifdef BCD_ADDER_SERIAL_CHECK_EN
  logic              bad_q, bad_d;
  logic              err_q, err_d;
  logic              in_bad;
`endif

  // Digit datapath: selects the current digit pair and produces the
  // corrected BCD digit plus carry.
  logic [3:0]        dig_a;
  logic [3:0]        dig_b;
  logic [4:0]        dig_t;
  logic [3:0]        dig_sum;
  logic              dig_cout;
  logic              last_dig;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    dig_t    = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
    dig_sum  = dig_t[3:0];
    dig_cout = 1'b0;
    if (dig_t >= 5'd10) begin
      dig_sum  = 4'(dig_t - 5'd10);
      dig_cout = 1'b1;
    end
  end

  assign last_dig = (cnt_q == CW'(N - 1));

`ifdef BCD_ADDER_SERIAL_CHECK_EN
  // Examined on the capture edge, so only the values actually latched count.
  always_comb begin
    in_bad = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (a[4*i +: 4] > 4'd9) in_bad = 1'b1;
      if (b[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end
`endif

  // Next-state and datapath update. soc and davC_ are Moore outputs of the
  // state being evaluated, so each appears one edge after the state is
  // entered. This is what places davC_ N+1 clocks after the capture edge.
  always_comb begin
    state_d = state_q;
    soc_d   = (state_q == S_START);
    dav_n_d = (state_q != S_DAV);
    z_d     = z_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      S_START: begin
        if (!eocA && !eocB) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (eocA && eocB) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
          bad_d   = in_bad;
          err_d   = 1'b0;
`endif
        end
      end

      S_ADD: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) z_d[4*i +: 4] = dig_sum;
        end
        carry_d = dig_cout;
        if (last_dig) begin
          z_d[4*N +: 4] = {3'b000, dig_cout};
          cnt_d         = '0;
          state_d       = S_DAV;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
          if (bad_q) begin
            for (int unsigned i = 0; i <= N; i++) z_d[4*i +: 4] = 4'd9;
          end
          err_d = bad_q;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DAV: begin
        if (!rfdC) state_d = S_END;
      end

      S_END: begin
        if (rfdC) begin
          state_d = S_START;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_START;
      soc_q   <= 1'b0;
      dav_n_q <= 1'b1;
      z_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      dav_n_q <= dav_n_d;
      z_q     <= z_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  assign socA  = soc_q;
  assign socB  = soc_q;
  assign davC_ = dav_n_q;
  assign z     = z_q;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
  assign err   = err_q;
`endif

endmodule

// File: tb/tb_bcd_adder_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder_serial
//
// Directed bench for bcd_adder_serial with N=4. The bench covers reset
// values, soc sequencing, capture latency, carry ripple and staggered eoc.
// It also covers the held DAV handshake and reset during ADD. When
// BCD_ADDER_SERIAL_CHECK_EN is defined, it also covers the err output.
// ---------------------------------------------------------------------------
module tb_bcd_adder_serial;

  logic        clock;
  logic        reset_;
  logic        socA, socB;
  logic        eocA, eocB;
  logic [15:0] a, b;
  logic        davC_;
  logic        rfdC;
  logic [19:0] z;
`ifdef BCD_ADDER_SERIAL_CHECK_EN
  logic        err;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  bcd_adder_serial #(.N(4)) dut (
    .clock (clock),
    .reset_(reset_),
    .socA  (socA),
    .socB  (socB),
    .eocA  (eocA),
    .eocB  (eocB),
    .a     (a),
    .b     (b),
    .davC_ (davC_),
    .rfdC  (rfdC),
    .z     (z)
`ifdef BCD_ADDER_SERIAL_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Called with eocA/eocB already high in WAIT. The next edge captures.
  // Operand inputs are then scrambled to show they are ignored outside WAIT.
  task automatic run_add(input string tag, input logic [19:0] exp_z, input logic exp_err);
    tick;
    eocA = 1'b0;
    eocB = 1'b0;
    a    = 16'h8888;
    b    = 16'h7777;
    for (int k = 1; k <= 5; k++) begin
      tick;
      check({tag, " davC_ latency"}, {19'd0, davC_}, (k == 5) ? 20'd0 : 20'd1);
    end
    check({tag, " z"}, z, exp_z);
`ifdef BCD_ADDER_SERIAL_CHECK_EN
    check({tag, " err"}, {19'd0, err}, {19'd0, exp_err});
`else
    if (exp_err) $display("note: %s expects err but feature is disabled", tag);
`endif
  endtask

  // From DAV back to WAIT through END and START.
  task automatic finish_handshake(input string tag);
    rfdC = 1'b0;
    tick;
    check({tag, " davC_ in END"}, {19'd0, davC_}, 20'd0);
    rfdC = 1'b1;
    tick;
    check({tag, " davC_ after END"}, {19'd0, davC_}, 20'd1);
    check({tag, " soc low leaving END"}, {18'd0, socA, socB}, 20'd0);
`ifdef BCD_ADDER_SERIAL_CHECK_EN
    check({tag, " err cleared"}, {19'd0, err}, 20'd0);
`endif
    tick;
    check({tag, " soc in START"}, {18'd0, socA, socB}, 20'h3);
    tick;
    check({tag, " soc in WAIT"}, {18'd0, socA, socB}, 20'h0);
  endtask

  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic [19:0] vz [4];
  logic [19:0] z_hold;

  initial begin
    reset_ = 1'b1;
    eocA   = 1'b0;
    eocB   = 1'b0;
    a      = '0;
    b      = '0;
    rfdC   = 1'b1;

    va[0] = 16'h0000; vb[0] = 16'h0000; vz[0] = 20'h00000;
    va[1] = 16'h5678; vb[1] = 16'h4567; vz[1] = 20'h10245;
    va[2] = 16'h9999; vb[2] = 16'h9999; vz[2] = 20'h19998;
    va[3] = 16'h0909; vb[3] = 16'h0191; vz[3] = 20'h01100;

    // Asynchronous reset, checked before any clock edge.
    #2 reset_ = 1'b0;
    #1;
    check("reset soc", {18'd0, socA, socB}, 20'h0);
    check("reset davC_", {19'd0, davC_}, 20'd1);
    check("reset z", z, 20'h0);
`ifdef BCD_ADDER_SERIAL_CHECK_EN
    check("reset err", {19'd0, err}, 20'd0);
`endif
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    tick;
    check("first edge soc", {18'd0, socA, socB}, 20'h3);
    tick;
    check("wait soc", {18'd0, socA, socB}, 20'h0);

    // 1234 + 4321, then DAV held for 10 clocks.
    a = 16'h1234; b = 16'h4321; eocA = 1'b1; eocB = 1'b1;
    run_add("op1234", 20'h05555, 1'b0);
    z_hold = z;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("dav hold davC_", {19'd0, davC_}, 20'd0);
      check("dav hold z", z, 20'h05555);
    end
    finish_handshake("op1234");

    // Carry ripples through every digit.
    a = 16'h9999; b = 16'h0001; eocA = 1'b1; eocB = 1'b1;
    run_add("op9999", 20'h10000, 1'b0);
    finish_handshake("op9999");

    // eocA leads eocB by three clocks; a changes while eocB is low.
    a = 16'h1111; b = 16'h2222; eocA = 1'b1; eocB = 1'b0;
    tick;
    a = 16'h3333;
    tick;
    tick;
    check("stagger no capture davC_", {19'd0, davC_}, 20'd1);
    check("stagger no capture z", z, 20'h10000);
    a = 16'h4444; eocB = 1'b1;
    run_add("stagger", 20'h06666, 1'b0);
    finish_handshake("stagger");

    for (int v = 0; v < 4; v++) begin
      a = va[v]; b = vb[v]; eocA = 1'b1; eocB = 1'b1;
      run_add("vector", vz[v], 1'b0);
      finish_handshake("vector");
    end

    // Reset during the second ADD cycle.
    a = 16'h1234; b = 16'h1111; eocA = 1'b1; eocB = 1'b1;
    tick;
    eocA = 1'b0; eocB = 1'b0;
    tick;
    #2 reset_ = 1'b0;
    #1;
    check("midadd reset soc", {18'd0, socA, socB}, 20'h0);
    check("midadd reset davC_", {19'd0, davC_}, 20'd1);
    check("midadd reset z", z, 20'h0);
    @(negedge clock);
    reset_ = 1'b1;
    tick;
    check("post reset soc", {18'd0, socA, socB}, 20'h3);
    tick;
    check("post reset wait soc", {18'd0, socA, socB}, 20'h0);
    a = 16'h1234; b = 16'h4321; eocA = 1'b1; eocB = 1'b1;
    run_add("post reset op", 20'h05555, 1'b0);
    finish_handshake("post reset op");

`ifdef BCD_ADDER_SERIAL_CHECK_EN
    a = 16'h001A; b = 16'h0005; eocA = 1'b1; eocB = 1'b1;
    run_add("bad digit", 20'h99999, 1'b1);
    tick;
    check("bad digit err held", {19'd0, err}, 20'd1);
    finish_handshake("bad digit");
    a = 16'h0001; b = 16'h0002; eocA = 1'b1; eocB = 1'b1;
    run_add("after bad", 20'h00003, 1'b0);
    finish_handshake("after bad");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
